// File: rtl/n64_cfg_cmd_queue.sv
// Purpose : queues N64 configuration commands (cmd byte + two args) and sequences them one at a time to the controller CPU.
// Latency : req_valid -> level 1 cycle, -> cmd_valid 2 cycles when idle; done_valid -> response/idle 1 cycle.
// Backpress: cmd_valid holds until cmd_ready; requests arriving on a full queue (with no same-cycle pop) are dropped and flagged.
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   req_valid/req_command/req_arg0/arg1   command write strobe and payload from the N64 register block
//   cmd_valid/cmd_ready/cmd_*             head command offered to the CPU (valid/ready)
//   done_valid/done_response              CPU completion strobe and its response word
//   busy, response, level                 N64-visible status: busy, last response, queued count
//   overflow, protocol_error, timeout     sticky error flags, cleared by flags_clear (a set in the same cycle wins)
//
// Optional feature: define N64_CFG_CMD_TIMEOUT_EN to enable the execution watchdog
// (TIMEOUT_CYCLES). Without it S_EXEC waits indefinitely and timeout is tied low.

module n64_cfg_cmd_queue #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   input  logic [7:0]             req_command,
   input  logic [31:0]            req_arg0,
   input  logic [31:0]            req_arg1,
   output logic                   busy,
   output logic [31:0]            response,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [7:0]             cmd_command,
   output logic [31:0]            cmd_arg0,
   output logic [31:0]            cmd_arg1,
   input  logic                   done_valid,
   input  logic [31:0]            done_response,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   protocol_error,
   output logic                   timeout,
   input  logic                   flags_clear
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   // Elaboration-time guard on the parameter ranges.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("n64_cfg_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OFFER = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0]  command;
      logic [31:0] arg0;
      logic [31:0] arg1;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   state_t        state;
   state_t        state_next;
   logic          push;
   logic          pop;
   logic          drop;
   logic          finish;
   logic          stray;
   logic          expire;

   // The head leaves the queue only when the CPU accepts it, so a full queue
   // can still take a new request in the cycle of a handshake.
   assign pop    = (state == S_OFFER) && cmd_ready;
   assign push   = req_valid && ((count < FULL_LEVEL) || pop);
   assign drop   = req_valid && !push;
   assign finish = (state == S_EXEC) && done_valid;
   assign stray  = done_valid && (state != S_EXEC);

   // ---------------------------------------------------------------- queue
   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{command: req_command, arg0: req_arg0, arg1: req_arg1};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign level = count;

   // Fields are forced to zero when nothing is offered so that the CPU-side
   // bus is quiet out of reset and between commands.
   assign cmd_command = cmd_valid ? head.command : '0;
   assign cmd_arg0    = cmd_valid ? head.arg0    : '0;
   assign cmd_arg1    = cmd_valid ? head.arg1    : '0;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_valid  = 1'b0;
      busy       = (count != '0) || (state != S_IDLE);
      unique case (state)
         S_IDLE: begin
            if (count != '0) state_next = S_OFFER;
         end
         S_OFFER: begin
            cmd_valid = 1'b1;
            if (cmd_ready) state_next = S_EXEC;
         end
         S_EXEC: begin
            if (done_valid || expire) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- watchdog
`ifdef N64_CFG_CMD_TIMEOUT_EN
   localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);

   logic [31:0] wd_cnt;
   logic        timeout_flag;

   // wd_cnt holds the number of completed cycles in S_EXEC; expiry fires on the
   // cycle that brings it to TIMEOUT_CYCLES. A real completion in that same
   // cycle takes precedence.
   assign expire = (state == S_EXEC) && !done_valid && ((wd_cnt + 32'd1) == WD_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt       <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (pop)                  wd_cnt <= '0;
         else if (state == S_EXEC) wd_cnt <= wd_cnt + 32'd1;

         if (expire)           timeout_flag <= 1'b1;
         else if (flags_clear) timeout_flag <= 1'b0;
      end
   end

   assign timeout = timeout_flag;
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   // ------------------------------------------------------ response / flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         response       <= '0;
         overflow       <= 1'b0;
         protocol_error <= 1'b0;
      end else begin
         if (finish)      response <= done_response;
         else if (expire) response <= 32'hFFFF_FFFF;

         if (drop)             overflow <= 1'b1;
         else if (flags_clear) overflow <= 1'b0;

         if (stray)            protocol_error <= 1'b1;
         else if (flags_clear) protocol_error <= 1'b0;
      end
   end

endmodule
